// File: rtl/plane_ctrl_pkg.sv
// Shared constants for the player-plane controller: coordinate width, direction
// codes, main/fire FSM encodings and the clamped step helper.
package plane_ctrl_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    F_READY = 2'd0,
    F_REQ   = 2'd1,
    F_COOL  = 2'd2
  } fire_e;

  // Saturating move: never wraps, pins to 0 or vmax when a full step would cross it.
  function automatic logic [COORD_W-1:0] clamp_step(input logic [COORD_W-1:0] v,
                                                    input logic inc, input int step,
                                                    input int vmax);
    if (inc) return (int'(v) > vmax - step) ? COORD_W'(vmax) : v + COORD_W'(step);
    else     return (int'(v) < step) ? '0 : v - COORD_W'(step);
  endfunction

endpackage

// File: rtl/fire_sched.sv
// Shot scheduler: READY -> REQ (hold until ack) -> COOL -> READY.
// AUTO_FIRE_EN: defined = held button re-fires; undefined = button must be released between shots.
module fire_sched
  import plane_ctrl_pkg::*;
#(
  parameter int FIRE_COOLDOWN = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_now,
  input  logic run_next,
  input  logic fire,
  input  logic ack,
  output logic fire_req
);

  localparam int CW        = $clog2(FIRE_COOLDOWN + 1);
  // COOL lasts FIRE_COOLDOWN-1 cycles so the next request lands FIRE_COOLDOWN clocks after the deassert cycle.
  localparam int COOL_LAST = (FIRE_COOLDOWN > 1) ? FIRE_COOLDOWN - 2 : 0;

  fire_e         st, nxt;
  logic [CW-1:0] cnt;
  logic          start;

`ifdef AUTO_FIRE_EN
  assign start = (st == F_READY) && run_now && run_next && fire;
`else
  logic armed;
  assign start = (st == F_READY) && run_now && run_next && fire && armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     armed <= 1'b1;
    else if (start) armed <= 1'b0;
    else if (!fire) armed <= 1'b1;
  end
`endif

  always_comb begin
    nxt = st;
    case (st)
      F_READY: if (start) nxt = F_REQ;
      // An ack that coincides with leaving RUN still completes the shot.
      F_REQ: begin
        if (ack)           nxt = F_COOL;
        else if (!run_next) nxt = F_READY;
      end
      F_COOL:  if (cnt == CW'(COOL_LAST)) nxt = F_READY;
      default: nxt = F_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= F_READY;
      cnt <= '0;
    end else begin
      st  <= nxt;
      cnt <= (st == F_COOL && nxt == F_COOL) ? cnt + CW'(1) : '0;
    end
  end

  assign fire_req = (st == F_REQ);

endmodule

// File: rtl/plane_ctrl.sv
// Player plane: main game FSM, periodic clamped movement and shot scheduling.
// Fire re-trigger behaviour is selected by AUTO_FIRE_EN (see fire_sched).
module plane_ctrl
  import plane_ctrl_pkg::*;
#(
  parameter int X_MAX         = 600,
  parameter int Y_MAX         = 440,
  parameter int X_INIT        = 300,
  parameter int Y_INIT        = 400,
  parameter int STEP          = 4,
  parameter int MOVE_PERIOD   = 250000,
  parameter int FIRE_COOLDOWN = 5000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_run_i,
  input  logic               move_en_i,
  input  logic [1:0]         direct_i,
  input  logic               fire_i,
  input  logic               hit_i,
  input  logic               fire_ack_i,
  output logic [COORD_W-1:0] pos_x_o,
  output logic [COORD_W-1:0] pos_y_o,
  output logic               fire_req_o,
  output logic [1:0]         state_o
);

  localparam int MW = $clog2(MOVE_PERIOD + 1);

  state_e        st, nxt;
  logic [MW-1:0] mcnt;
  logic          moving, tick;

  always_comb begin
    nxt = st;
    case (st)
      ST_IDLE: if (game_run_i) nxt = ST_RUN;
      ST_RUN: begin
        if (hit_i)            nxt = ST_DEAD;
        else if (!game_run_i) nxt = ST_IDLE;
      end
      ST_DEAD: if (!game_run_i) nxt = ST_WAIT;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= nxt;
  end

  // Counter only restarts when the press drops; direction changes keep the phase.
  assign moving = (st == ST_RUN) && move_en_i;
  assign tick   = moving && (mcnt == MW'(MOVE_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= '0;
    else        mcnt <= (moving && !tick) ? mcnt + MW'(1) : '0;
  end

  // Loading on next==IDLE makes the home position visible on the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_o <= COORD_W'(X_INIT);
      pos_y_o <= COORD_W'(Y_INIT);
    end else if (nxt == ST_IDLE) begin
      pos_x_o <= COORD_W'(X_INIT);
      pos_y_o <= COORD_W'(Y_INIT);
    end else if (tick) begin
      case (direct_i)
        DIR_UP:    pos_y_o <= clamp_step(pos_y_o, 1'b0, STEP, Y_MAX);
        DIR_DOWN:  pos_y_o <= clamp_step(pos_y_o, 1'b1, STEP, Y_MAX);
        DIR_LEFT:  pos_x_o <= clamp_step(pos_x_o, 1'b0, STEP, X_MAX);
        default:   pos_x_o <= clamp_step(pos_x_o, 1'b1, STEP, X_MAX);
      endcase
    end
  end

  fire_sched #(.FIRE_COOLDOWN(FIRE_COOLDOWN)) u_fire (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_now  (st == ST_RUN),
    .run_next (nxt == ST_RUN),
    .fire     (fire_i),
    .ack      (fire_ack_i),
    .fire_req (fire_req_o)
  );

  assign state_o = st;

endmodule

// File: doc/plane_ctrl.md
PLANE_CTRL -- requirements
Module: plane_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- X_MAX, 600, rightmost legal plane x coordinate.
- Y_MAX, 440, bottom legal plane y coordinate.
- X_INIT, 300, x coordinate after reset or restart.
- Y_INIT, 400, y coordinate after reset or restart.
- STEP, 4, pixels moved per move tick.
- MOVE_PERIOD, 250000, clocks between move ticks.
- FIRE_COOLDOWN, 5000000, clocks between shots.

REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- game_run_i, in, 1, level: game in progress.
- move_en_i, in, 1, single-direction press valid.
- direct_i, in, 2, direction code (`UP/`DOWN/`LEFT/`RIGHT).
- fire_i, in, 1, fire button level.
- hit_i, in, 1, one-cycle plane-hit pulse.
- fire_ack_i, in, 1, bullet engine accepted the shot.
- pos_x_o, out, 10, plane x.
- pos_y_o, out, 10, plane y.
- fire_req_o, out, 1, shot request.
- state_o, out, 2, FSM state.

REQ-003 There SHALL be one clock domain (clk); reset SHALL be asynchronous and active-low (rst_n). All inputs SHALL be synchronous to clk.

Function
REQ-004 The main FSM SHALL have four states, encoded on state_o: IDLE=2'd0, RUN=2'd1, DEAD=2'd2, WAIT=2'd3.
REQ-005 FSM transitions:
- IDLE->RUN when game_run_i=1.
- RUN->DEAD on hit_i=1.
- RUN->IDLE when game_run_i=0.
- DEAD->WAIT when game_run_i=0.
- WAIT->IDLE after one cycle.
- If hit_i and game_run_i=0 occur in the same cycle in RUN, the FSM SHALL go to DEAD.
REQ-006 A move counter SHALL count 0..MOVE_PERIOD-1 while in RUN with move_en_i=1, and SHALL issue a move tick on wrap to 0. The counter SHALL clear to 0 whenever move_en_i=0 or the state is not RUN.
REQ-007 On a move tick, position SHALL change by STEP in direct_i: `UP decreases y, `DOWN increases y, `LEFT decreases x, `RIGHT increases x. The update SHALL be registered and visible on the cycle after the tick.
REQ-008 Position arithmetic SHALL clamp to the range 0..X_MAX and 0..Y_MAX:
- No wrap-around.
- If x<STEP, `LEFT yields 0.
- If x>X_MAX-STEP, `RIGHT yields X_MAX.
- Y clamps the same way against 0 and Y_MAX.
REQ-009 The first move tick SHALL occur MOVE_PERIOD clocks after move_en_i rises. A direction change without move_en_i dropping SHALL NOT restart the counter.
REQ-010 Position SHALL load X_INIT/Y_INIT in IDLE and SHALL hold in DEAD and WAIT.
REQ-011 The fire sub-FSM SHALL have three states:
- READY: in RUN with fire_i=1, assert fire_req_o next cycle and enter REQ.
- REQ: hold fire_req_o=1 until fire_ack_i=1, then deassert fire_req_o the next cycle and enter COOL.
- COOL: count FIRE_COOLDOWN clocks, then return to READY.
REQ-012 fire_ack_i SHALL be ignored outside REQ. If fire_req_o=1 and the main FSM leaves RUN, fire_req_o SHALL drop the next cycle and the fire sub-FSM SHALL return to READY.
REQ-013 If hit_i and fire_ack_i occur in the same cycle, the ack SHALL complete (the shot counts) and the main FSM SHALL go to DEAD.

Reset
REQ-014 While rst_n=0, the block SHALL hold:
- state_o=IDLE.
- pos_x_o=X_INIT, pos_y_o=Y_INIT.
- fire_req_o=0.
- Both counters at 0.
- Fire sub-FSM in READY.
REQ-015 Reset asserted mid-move or mid-cooldown SHALL abort the operation; no tick or request SHALL follow reset release until the full normal latency has elapsed.

Configuration
REQ-016 Macro AUTO_FIRE_EN SHALL select the fire behaviour:
- Defined: holding fire_i=1 re-issues a request at each return to READY.
- Undefined: a new request additionally requires fire_i to have been 0 for at least one cycle since the last request (edge-triggered).

Structure
REQ-017 The following SHALL live in the shared header define.v, alongside existing constants:
- Direction codes `UP, `DOWN, `LEFT, `RIGHT.
- FSM state encodings.
- Coordinate width (10).
REQ-018 The fire sub-FSM with its cooldown counter SHALL be a sub-module named fire_sched. Movement and the main FSM SHALL stay in plane_ctrl.

Verification (MOVE_PERIOD=4, FIRE_COOLDOWN=8, STEP=4)
REQ-019 Scenario: game_run_i=1, move_en_i=1, direct_i=`RIGHT for 16 clocks -> pos_x_o 300->316 in 4 steps, first change 4 clocks after press.
REQ-020 Scenario: x=598, `RIGHT tick -> pos_x_o=600; a further tick keeps 600. y=2, `UP tick -> pos_y_o=0.
REQ-021 Scenario: fire_i held, fire_ack_i returned 3 cycles after request ->
- fire_req_o high for 3 cycles.
- Next request 8 clocks after the ack-deassert cycle with AUTO_FIRE_EN defined.
- No next request without the macro until fire_i toggles.
REQ-022 Scenario: hit_i pulse during REQ -> state_o=DEAD, fire_req_o=0 next cycle, position frozen. game_run_i=0 -> WAIT then IDLE with position (300,400).
REQ-023 Scenario: rst_n low mid-cooldown and mid-move -> all outputs at reset values asynchronously. After release, the first tick and first request SHALL appear only after the full period.
